ysyx_23060180_lsu: RTL
======================

YSYX_23060180_LSU -- requirements
Module: ysyx_23060180_lsu

Interface
REQ-001 Parameter ADDR_W, default 32, address width in bits.
REQ-002 Parameter DATA_W, default 32, memory bus width in bits; legal values 32 and 64.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles spent in REQ plus WAIT before the access is aborted; legal range 1..65535.
REQ-004 Ports, in order name / direction / width / meaning:
- clk, in, 1, the single clock; all state updates on its rising edge.
- rstn_in, in, 1, asynchronous active-low reset.
- req_valid, in, 1, core presents an access.
- req_ready, out, 1, LSU can accept an access.
- req_wr, in, 1, 1 = store, 0 = load.
- req_size, in, 2, access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned, in, 1, zero-extend load data (lbu/lhu/lwu).
- req_addr, in, ADDR_W, byte address.
- req_wdata, in, DATA_W, store data, LSB-aligned.
- rsp_valid, out, 1, one-cycle response pulse.
- rsp_data, out, DATA_W, extended load data; 0 for stores and errors.
- rsp_err, out, 1, misaligned access or timeout; valid with rsp_valid.
- mem_rd, out, 1, read request.
- mem_wr, out, 1, write request.
- mem_addr, out, ADDR_W, bus-aligned address.
- mem_wdata, out, DATA_W, lane-shifted store data.
- mem_wstrb, out, DATA_W/8, byte write strobes.
- mem_ready, in, 1, memory accepts mem_rd/mem_wr this cycle.
- mem_rvalid, in, 1, read data valid.
- mem_rdata, in, DATA_W, read data.

Function
REQ-005 The FSM SHALL have states IDLE, REQ, WAIT and RESP, with IDLE entered on reset.
REQ-006 req_ready SHALL be 1 only in IDLE; an access is accepted on a cycle with req_valid && req_ready, and all request fields are registered on that cycle.
REQ-007 An access is misaligned if req_addr mod 2^req_size != 0, or if 2^req_size > DATA_W/8. A misaligned access SHALL go IDLE->RESP, issue no mem_rd/mem_wr, and respond with rsp_err=1 and rsp_data=0 one cycle after acceptance.
REQ-008 An aligned access SHALL go IDLE->REQ, with the access timeout counter cleared to 0.
REQ-009 While in REQ, the LSU SHALL hold the following stable until mem_ready=1:
- mem_rd = !wr, or mem_wr = wr;
- mem_addr = addr with the low log2(DATA_W/8) bits cleared;
- mem_wstrb = ((1<<2^size)-1) << offset, where offset = addr low bits;
- mem_wdata = wdata << (8*offset).
REQ-010 mem_rd, mem_wr, mem_wstrb and mem_wdata SHALL be 0 in every state other than REQ.
REQ-011 On REQ with mem_ready=1, a store SHALL go to RESP, and a load SHALL go to WAIT.
REQ-012 In WAIT, on mem_rvalid=1 the LSU SHALL go to RESP and form rsp_data as follows:
- take mem_rdata >> (8*offset), truncated to 2^size bytes;
- sign-extend it to DATA_W, or zero-extend it if unsigned=1.
mem_rvalid coinciding with the mem_ready cycle SHALL be ignored (minimum load latency is ready + 1 cycle).
REQ-013 The timeout counter SHALL increment every cycle in REQ or WAIT. When it reaches TIMEOUT without completion, the LSU SHALL go to RESP with rsp_err=1 and rsp_data=0. Completion on the same cycle as expiry takes precedence over the timeout.
REQ-014 RESP SHALL last exactly one cycle with rsp_valid=1 and SHALL then return to IDLE; rsp_data and rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-015 mem_rvalid received in IDLE, REQ or RESP SHALL be ignored with no state change.
REQ-016 Minimum access latency, from accept to rsp_valid:
- misaligned: 1 cycle;
- store with immediate mem_ready: 2 cycles;
- load with immediate ready and rvalid on the next cycle: 3 cycles.
REQ-017 Back-to-back accesses SHALL be accepted on the cycle after RESP.

Reset
REQ-018 When rstn_in=0, the LSU SHALL asynchronously force state=IDLE and counter=0, with all outputs 0 except req_ready, which SHALL be 1.
REQ-019 Reset asserted mid-access SHALL discard the access with no response, and any mem_rvalid arriving after reset release SHALL be ignored.

Verification
REQ-020 Signed byte load: DATA_W=32, load, size 0, signed, addr 0x80000003, mem_rdata 0x80112233 -> mem_addr 0x80000000, rsp_data 0xFFFFFF80, rsp_err=0.
REQ-021 Halfword store: store, size 1, addr 0x80000002, wdata 0x0000ABCD -> mem_wr=1, mem_addr 0x80000000, mem_wstrb 4'b1100, mem_wdata[31:16]=0xABCD, rsp_valid 2 cycles after accept with immediate mem_ready.
REQ-022 Misaligned word load: load, size 2, addr 0x80000002 -> no mem_rd, rsp_valid with rsp_err=1 and rsp_data=0 one cycle after accept.
REQ-023 Timeout: TIMEOUT=8, mem_ready held 0 -> rsp_err=1 eight cycles after entering REQ, then req_ready=1 the following cycle.
REQ-024 Wide unsigned halfword: DATA_W=64, load, size 1, unsigned, addr 0x80000006, mem_rdata 0xBEEF000000000000 -> mem_strobe-free read at 0x80000000, rsp_data 0x000000000000BEEF; then a second request accepted the cycle after RESP.
REQ-025 Reset in WAIT: assert rstn_in during WAIT, release, then pulse mem_rvalid -> no rsp_valid, req_ready=1, all mem_* outputs 0.

Source files
------------

// File: rtl/ysyx_23060180_lsu.sv
// Load/store unit: accepts one core access at a time, checks alignment,
// drives a single-beat memory request with lane-shifted data and strobes,
// and returns extended load data or an error as a one-cycle response.
module ysyx_23060180_lsu #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rstn_in,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int          STRB_W   = DATA_W / 8;
  localparam int          OFF_W    = $clog2(STRB_W);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  logic                misaligned;
  logic                expired;
  logic                in_req;
  logic [OFF_W-1:0]    off;
  logic [DATA_W-1:0]   shifted;
  logic [DATA_W-1:0]   load_ext;
  logic [STRB_W-1:0]   strb_base;

  assign off     = addr_q[OFF_W-1:0];
  assign expired = (cnt_q == CNT_LAST);
  assign in_req  = (state_q == S_REQ);

  // Alignment check on the incoming request; a double is never legal on a 32-bit bus.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    misaligned = 1'b0;
    unique case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = (|req_addr[2:0]) || (STRB_W < 8);
    endcase
  end

  // Move the addressed bytes of the read beat down to bit 0 and extend them.
  always_comb begin
    shifted  = mem_rdata >> {off, 3'b000};
    load_ext = '0;
    unique case (size_q)
      2'd0:    load_ext = uns_q ? DATA_W'(shifted[7:0])  : DATA_W'($signed(shifted[7:0]));
      2'd1:    load_ext = uns_q ? DATA_W'(shifted[15:0]) : DATA_W'($signed(shifted[15:0]));
      2'd2:    load_ext = uns_q ? DATA_W'(shifted[31:0]) : DATA_W'($signed(shifted[31:0]));
      default: load_ext = shifted;
    endcase
  end

  // Unshifted strobe pattern: one bit per byte of the access size.
  always_comb begin
    strb_base = '0;
    unique case (size_q)
      2'd0:    strb_base = STRB_W'(8'h01);
      2'd1:    strb_base = STRB_W'(8'h03);
      2'd2:    strb_base = STRB_W'(8'h0F);
      default: strb_base = '1;
    endcase
  end

  // Next-state logic. The response registers default to 0 so they only carry
  // data/error for the single RESP cycle that follows their load.
  // A load that sees mem_ready on the expiry cycle has not completed yet,
  // so it times out; only a store handshake or read data beats the timeout.
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rsp_data_d = '0;
    rsp_err_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d      = req_wr;
          size_d    = req_size;
          uns_d     = req_unsigned;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          cnt_d     = '0;
          rsp_err_d = misaligned;
          state_d   = misaligned ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 16'd1;
        if (mem_ready && wr_q) begin
          state_d = S_RESP;
        end else if (expired) begin
          state_d   = S_RESP;
          rsp_err_d = 1'b1;
        end else if (mem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (mem_rvalid) begin
          state_d    = S_RESP;
          rsp_data_d = load_ext;
        end else if (expired) begin
          state_d   = S_RESP;
          rsp_err_d = 1'b1;
        end
      end
      S_RESP: state_d = S_IDLE;
    endcase
  end

  // State and captured-request registers.
  always_ff @(posedge clk or negedge rstn_in) begin
    // NOTE: datapath registers are reset too, so mem_* and rsp_* read 0 straight out of reset.
    if (!rstn_in) begin
      state_q    <= S_IDLE;
      wr_q       <= 1'b0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      wr_q       <= wr_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  // Bus drive exists only in REQ; reads carry no strobes or write data.
  assign mem_rd    = in_req && !wr_q;
  assign mem_wr    = in_req && wr_q;
  assign mem_addr  = in_req ? {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)} : '0;
  assign mem_wstrb = mem_wr ? (strb_base << off) : '0;
  assign mem_wdata = mem_wr ? (wdata_q << {off, 3'b000}) : '0;

endmodule
